// File: rtl/dice_roll_sequencer_if.sv
// Request/result bundle between a roll requester and dice_roll_sequencer.
interface dice_roll_sequencer_if;
  logic       roll_req;
  logic [1:0] roll_sel;
  logic [2:0] dice1;
  logic [2:0] dice2;
  logic       rolled1;
  logic       rolled2;
  logic       busy;
  logic [7:0] roll_count;

  modport master (
    output roll_req,
    output roll_sel,
    input  dice1,
    input  dice2,
    input  rolled1,
    input  rolled2,
    input  busy,
    input  roll_count
  );

  modport slave (
    input  roll_req,
    input  roll_sel,
    output dice1,
    output dice2,
    output rolled1,
    output rolled2,
    output busy,
    output roll_count
  );
endinterface

// File: rtl/dice_roll_sequencer.sv
// Dice roll sequencer: spins two free-running die counters, captures die 1 and
// then die 2 after a fixed gap, and emits one-cycle strobes with the values.
module dice_roll_sequencer #(
  parameter int unsigned SPIN_CYCLES = 8,  // 1..255
  parameter int unsigned GAP_CYCLES  = 2   // 0..255
) (
  input  logic                  clk,
  input  logic                  rst,
  dice_roll_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StSpin, StShow1, StGap, StShow2} state_e;

  localparam logic [7:0] SpinLast = 8'(SPIN_CYCLES - 1);
  // Only used when GAP_CYCLES > 0; the zero case bypasses the GAP state.
  localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);
  localparam bit         HasGap   = (GAP_CYCLES != 0);

  state_e     state_q;
  logic [1:0] sel_q;
  logic [7:0] spin_cnt_q;
  logic [7:0] gap_cnt_q;
  logic [2:0] c1_q;
  logic [2:0] c2_q;
  logic [2:0] dice1_q;
  logic [2:0] dice2_q;
  logic       rolled1_q;
  logic       rolled2_q;
  logic       busy_q;
  logic [7:0] roll_count_q;

  // Free-running die counters: c1 every cycle, c2 on each c1 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q <= 3'd1;
      c2_q <= 3'd1;
    end else if (c1_q == 3'd6) begin
      c1_q <= 3'd1;
      c2_q <= (c2_q == 3'd6) ? 3'd1 : c2_q + 3'd1;
    end else begin
      c1_q <= c1_q + 3'd1;
    end
  end

  // Roll FSM with registered strobes, dice values, busy and completion count.
  // Strobes and dice are loaded on the edge entering SHOW1/SHOW2, so the
  // captured value is the counter as it stood in the cycle before the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      sel_q        <= 2'b00;
      spin_cnt_q   <= 8'd0;
      gap_cnt_q    <= 8'd0;
      dice1_q      <= 3'd1;
      dice2_q      <= 3'd1;
      rolled1_q    <= 1'b0;
      rolled2_q    <= 1'b0;
      busy_q       <= 1'b0;
      roll_count_q <= 8'd0;
    end else begin
      rolled1_q <= 1'b0;
      rolled2_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.roll_req && (bus.roll_sel != 2'b00)) begin
            sel_q      <= bus.roll_sel;
            spin_cnt_q <= 8'd0;
            busy_q     <= 1'b1;
            state_q    <= StSpin;
          end
        end
        StSpin: begin
          if (spin_cnt_q == SpinLast) begin
            if (sel_q[0]) begin
              dice1_q   <= c1_q;
              rolled1_q <= 1'b1;
              state_q   <= StShow1;
            end else begin
              dice2_q   <= c2_q;
              rolled2_q <= 1'b1;
              state_q   <= StShow2;
            end
          end else begin
            spin_cnt_q <= spin_cnt_q + 8'd1;
          end
        end
        StShow1: begin
          if (!sel_q[1]) begin
            busy_q       <= 1'b0;
            roll_count_q <= roll_count_q + 8'd1;
            state_q      <= StIdle;
          end else if (HasGap) begin
            gap_cnt_q <= 8'd0;
            state_q   <= StGap;
          end else begin
            dice2_q   <= c2_q;
            rolled2_q <= 1'b1;
            state_q   <= StShow2;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapLast) begin
            dice2_q   <= c2_q;
            rolled2_q <= 1'b1;
            state_q   <= StShow2;
          end else begin
            gap_cnt_q <= gap_cnt_q + 8'd1;
          end
        end
        StShow2: begin
          busy_q       <= 1'b0;
          roll_count_q <= roll_count_q + 8'd1;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.dice1      = dice1_q;
  assign bus.dice2      = dice2_q;
  assign bus.rolled1    = rolled1_q;
  assign bus.rolled2    = rolled2_q;
  assign bus.busy       = busy_q;
  assign bus.roll_count = roll_count_q;

endmodule

// File: tb/tb_dice_roll_sequencer.sv
// Directed bench for dice_roll_sequencer: instance A (S=8, G=2) and
// instance B (S=1, G=0), checked cycle by cycle against hand-computed values.
module tb_dice_roll_sequencer;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  dice_roll_sequencer_if bus_a ();
  dice_roll_sequencer_if bus_b ();

  dice_roll_sequencer #(
    .SPIN_CYCLES(8),
    .GAP_CYCLES (2)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(bus_a)
  );

  dice_roll_sequencer #(
    .SPIN_CYCLES(1),
    .GAP_CYCLES (0)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b)
  );

  int errors = 0;
  int checks = 0;
  int k      = 0;
  int n1;
  int n2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Check busy/strobes every cycle from the current k through 'last'; busy is
  // expected in [bl, bh], rolled1 only at k1 (dice1=d1), rolled2 only at k2.
  task automatic watch(input bit inst_b, input int last, input int bl, input int bh,
                       input int k1, input int d1, input int k2, input int d2);
    logic       b;
    logic       r1;
    logic       r2;
    logic [2:0] v1;
    logic [2:0] v2;
    while (k <= last) begin
      b  = inst_b ? bus_b.busy    : bus_a.busy;
      r1 = inst_b ? bus_b.rolled1 : bus_a.rolled1;
      r2 = inst_b ? bus_b.rolled2 : bus_a.rolled2;
      v1 = inst_b ? bus_b.dice1   : bus_a.dice1;
      v2 = inst_b ? bus_b.dice2   : bus_a.dice2;
      check("busy", 32'(b), 32'(k >= bl && k <= bh));
      check("rolled1", 32'(r1), 32'(k == k1));
      check("rolled2", 32'(r2), 32'(k == k2));
      if (k == k1) check("dice1", 32'(v1), 32'(d1));
      if (k == k2) check("dice2", 32'(v2), 32'(d2));
      tick();
    end
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    k = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at k=%0d", k);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.roll_req = 1'b0;
    bus_a.roll_sel = 2'b00;
    bus_b.roll_req = 1'b0;
    bus_b.roll_sel = 2'b00;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();

    // Reset state
    check("rst_busy", 32'(bus_a.busy), 32'd0);
    check("rst_dice1", 32'(bus_a.dice1), 32'd1);
    check("rst_dice2", 32'(bus_a.dice2), 32'd1);
    check("rst_rolled", 32'({bus_a.rolled1, bus_a.rolled2}), 32'd0);
    check("rst_count", 32'(bus_a.roll_count), 32'd0);
    rst_a = 1'b0;
    k = 0;

    // Scenario 1: sel=11 at k=3
    watch(1'b0, 2, 1, 0, -1, 0, -1, 0);
    bus_a.roll_req = 1'b1;
    bus_a.roll_sel = 2'b11;
    tick();
    bus_a.roll_req = 1'b0;
    bus_a.roll_sel = 2'b00;
    watch(1'b0, 15, 4, 15, 12, 6, 15, 3);
    check("s1_count", 32'(bus_a.roll_count), 32'd1);

    // Scenario 2: sel=01 at k=20, die 2 untouched
    watch(1'b0, 19, 1, 0, -1, 0, -1, 0);
    bus_a.roll_req = 1'b1;
    bus_a.roll_sel = 2'b01;
    tick();
    bus_a.roll_req = 1'b0;
    bus_a.roll_sel = 2'b00;
    watch(1'b0, 29, 21, 29, 29, 5, -1, 0);
    check("s2_count", 32'(bus_a.roll_count), 32'd2);
    check("s2_dice2_hold", 32'(bus_a.dice2), 32'd3);
    check("s2_dice1_hold", 32'(bus_a.dice1), 32'd5);

    // Scenario 3: sel=00 ignored, then sel=11 at k=5 with extra pulse at k=9
    reset_a();
    watch(1'b0, 2, 1, 0, -1, 0, -1, 0);
    bus_a.roll_req = 1'b1;
    bus_a.roll_sel = 2'b00;
    tick();
    bus_a.roll_req = 1'b0;
    watch(1'b0, 4, 1, 0, -1, 0, -1, 0);
    bus_a.roll_req = 1'b1;
    bus_a.roll_sel = 2'b11;
    tick();
    bus_a.roll_req = 1'b0;
    bus_a.roll_sel = 2'b00;
    watch(1'b0, 8, 6, 17, 14, 2, 17, 3);
    bus_a.roll_req = 1'b1;
    bus_a.roll_sel = 2'b11;
    watch(1'b0, 9, 6, 17, 14, 2, 17, 3);
    bus_a.roll_req = 1'b0;
    bus_a.roll_sel = 2'b00;
    watch(1'b0, 18, 6, 17, 14, 2, 17, 3);
    check("s3_count", 32'(bus_a.roll_count), 32'd1);

    // Scenario 4: roll started at k=19, reset mid-SPIN at k=23
    bus_a.roll_req = 1'b1;
    bus_a.roll_sel = 2'b11;
    tick();
    bus_a.roll_req = 1'b0;
    bus_a.roll_sel = 2'b00;
    watch(1'b0, 22, 20, 31, -1, 0, -1, 0);
    rst_a = 1'b1;
    tick();
    check("s4_busy", 32'(bus_a.busy), 32'd0);
    check("s4_dice1", 32'(bus_a.dice1), 32'd1);
    check("s4_dice2", 32'(bus_a.dice2), 32'd1);
    check("s4_count", 32'(bus_a.roll_count), 32'd0);
    check("s4_rolled", 32'({bus_a.rolled1, bus_a.rolled2}), 32'd0);
    rst_a = 1'b0;
    k = 0;
    watch(1'b0, 4, 1, 0, -1, 0, -1, 0);
    bus_a.roll_req = 1'b1;
    bus_a.roll_sel = 2'b01;
    tick();
    bus_a.roll_req = 1'b0;
    bus_a.roll_sel = 2'b00;
    watch(1'b0, 15, 6, 14, 14, 2, -1, 0);
    check("s4_count_after", 32'(bus_a.roll_count), 32'd1);

    // Scenario 5: instance B, S=1 G=0, sel=11 at k=0
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    k = 0;
    bus_b.roll_req = 1'b1;
    bus_b.roll_sel = 2'b11;
    tick();
    bus_b.roll_req = 1'b0;
    bus_b.roll_sel = 2'b00;
    watch(1'b1, 4, 1, 3, 2, 2, 3, 1);
    check("s5_count", 32'(bus_b.roll_count), 32'd1);

    // Scenario 6: 256 back-to-back sel=10 rolls, one every 10 cycles
    reset_a();
    bus_a.roll_req = 1'b1;
    bus_a.roll_sel = 2'b10;
    n1 = 0;
    n2 = 0;
    while (n2 < 256 && k < 2700) begin
      if (bus_a.rolled1) n1++;
      if (bus_a.rolled2) begin
        check("s6_count", 32'(bus_a.roll_count), 32'(n2 % 256));
        check("s6_strobe_k", 32'(k % 10), 32'd9);
        check("s6_dice2", 32'(bus_a.dice2), 32'((((k - 1) / 6) % 6) + 1));
        check("s6_dice2_range", 32'(bus_a.dice2 >= 3'd1 && bus_a.dice2 <= 3'd6), 32'd1);
        n2++;
        if (n2 == 256) begin
          bus_a.roll_req = 1'b0;
          bus_a.roll_sel = 2'b00;
        end
      end
      tick();
    end
    check("s6_rolled2_total", 32'(n2), 32'd256);
    check("s6_rolled1_total", 32'(n1), 32'd0);
    check("s6_count_wrap", 32'(bus_a.roll_count), 32'd0);
    check("s6_busy", 32'(bus_a.busy), 32'd0);
    check("s6_dice1", 32'(bus_a.dice1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
